// File: rtl/my_mst_chan_mux_pkg.sv
// Shared width helpers for the multi-channel en/rdy merge block.
package my_mst_chan_mux_pkg;

  function automatic int ch_w_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int lvl_w_f(input int d);
    return $clog2(d + 1);
  endfunction

endpackage

// File: rtl/my_mst_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after rr_ptr and
// advances rr_ptr past the winner whenever a grant is issued.
module my_mst_rr_arb
  import my_mst_chan_mux_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = ch_w_f(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] i_req,
  input  logic              i_en,
  output logic [NUM_CH-1:0] o_gnt,
  output logic [CH_W-1:0]   o_idx,
  output logic              o_vld,
  output logic [CH_W-1:0]   o_rr_ptr
);

  logic [CH_W-1:0] r_ptr;
  int              w_j;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_vld = 1'b0;
    w_j   = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_j = (int'(r_ptr) + k) % NUM_CH;
      if (!o_vld && i_en && i_req[w_j]) begin
        o_vld      = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = CH_W'(w_j);
      end
    end
  end

  // A grant is always a transfer, since grant bits are only set on requesting channels.
  always_ff @(posedge clk) begin
    if (rst)
      r_ptr <= '0;
    else if (o_vld)
      r_ptr <= (o_idx == CH_W'(NUM_CH - 1)) ? '0 : o_idx + CH_W'(1);
  end

  assign o_rr_ptr = r_ptr;

endmodule

// File: rtl/my_mst_chan_mux.sv
// Merges NUM_CH en/rdy channels through a round-robin arbiter into a DEPTH-entry
// tagged FIFO. Define MY_MST_CHAN_MUX_STATS_EN to add per-channel transfer counters.
module my_mst_chan_mux
  import my_mst_chan_mux_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 4,
  localparam int CH_W   = ch_w_f(NUM_CH),
  localparam int LW     = lvl_w_f(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0]        ch_rdy,
  output logic                     out_en,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  input  logic                     out_rdy,
  output logic [LW-1:0]            fifo_level
`ifdef MY_MST_CHAN_MUX_STATS_EN
  ,
  output logic [NUM_CH*16-1:0]     stats_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t          r_mem [DEPTH];
  entry_t          r_head;
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [LW-1:0]   r_level;

  logic [NUM_CH-1:0] w_gnt;
  logic [CH_W-1:0]   w_idx, w_rr_ptr;
  logic              w_push, w_pop, w_can_push;
  logic [AW-1:0]     w_rptr_nxt;
  entry_t            w_wdata, w_head_nxt;

  assign w_pop      = (r_level != '0) && out_rdy;
  // Full is only escapable by a same-cycle pop, hence the out_rdy term.
  assign w_can_push = (r_level != LW'(DEPTH)) || out_rdy;

  my_mst_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_req    (ch_en),
    .i_en     (w_can_push && !rst),
    .o_gnt    (w_gnt),
    .o_idx    (w_idx),
    .o_vld    (w_push),
    .o_rr_ptr (w_rr_ptr)
  );

  assign w_wdata    = '{ch: w_idx, data: ch_data[w_idx*DATA_W +: DATA_W]};
  assign w_rptr_nxt = r_rptr + AW'(w_pop);
  // The incoming word becomes head only when everything ahead of it leaves this cycle.
  assign w_head_nxt = (w_push && (r_level == LW'(w_pop))) ? w_wdata : r_mem[w_rptr_nxt];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_head  <= '0;
    end else begin
      r_wptr  <= r_wptr + AW'(w_push);
      r_rptr  <= w_rptr_nxt;
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
      r_head  <= w_head_nxt;
    end
  end

  assign ch_rdy     = w_gnt;
  assign out_en     = (r_level != '0);
  assign out_data   = r_head.data;
  assign out_ch     = r_head.ch;
  assign fifo_level = r_level;

`ifdef MY_MST_CHAN_MUX_STATS_EN
  logic [NUM_CH-1:0][15:0] r_stats;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_stats
    always_ff @(posedge clk) begin
      if (rst)
        r_stats[i] <= '0;
      else if (w_gnt[i] && (r_stats[i] != 16'hFFFF))
        r_stats[i] <= r_stats[i] + 16'd1;
    end
  end

  assign stats_cnt = r_stats;
`endif

endmodule

// File: tb/tb_my_mst_chan_mux.sv
// Randomised bench for my_mst_chan_mux against a queue-based reference model.
module tb_my_mst_chan_mux;
  localparam int NCH = 4, DW = 32, DEP = 4, CHW = 2, LW = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NCH-1:0]    ch_en = '1;
  logic [NCH*DW-1:0] ch_data = '0;
  logic [NCH-1:0]    ch_rdy;
  logic              out_en;
  logic [DW-1:0]     out_data;
  logic [CHW-1:0]    out_ch;
  logic              out_rdy = 1'b0;
  logic [LW-1:0]     fifo_level;
`ifdef MY_MST_CHAN_MUX_STATS_EN
  logic [NCH*16-1:0] stats_cnt;
`endif

  always #5 clk = ~clk;

  my_mst_chan_mux #(.NUM_CH(NCH), .DATA_W(DW), .DEPTH(DEP)) dut (
    .clk(clk), .rst(rst), .ch_en(ch_en), .ch_data(ch_data), .ch_rdy(ch_rdy),
    .out_en(out_en), .out_data(out_data), .out_ch(out_ch), .out_rdy(out_rdy),
    .fifo_level(fifo_level)
`ifdef MY_MST_CHAN_MUX_STATS_EN
    , .stats_cnt(stats_cnt)
`endif
  );

  typedef struct { int ch; logic [DW-1:0] data; } ent_t;
  typedef struct {
    logic [NCH-1:0] rdy, xrdy;
    logic           en, xen;
    logic [DW-1:0]  dat, xdat;
    logic [CHW-1:0] ch, xch;
    logic [LW-1:0]  lvl, xlvl;
    int             g;
  } snap_t;

  ent_t q[$];
  int   rr = 0;
  int   n_chk = 0, n_pass = 0;

  // One clock: sample DUT at negedge alongside model expectations, advance model at posedge.
  task automatic cycle(output snap_t s);
    bit can_push;
    @(negedge clk);
    s.g = -1;
    can_push = !rst && (q.size() < DEP || out_rdy);
    if (can_push)
      for (int k = 0; k < NCH; k++) begin
        int j = (rr + k) % NCH;
        if (s.g < 0 && ch_en[j]) s.g = j;
      end
    s.xrdy = '0;
    if (s.g >= 0) s.xrdy[s.g] = 1'b1;
    s.xen  = q.size() != 0;
    s.xlvl = LW'(q.size());
    s.xdat = s.xen ? q[0].data : '0;
    s.xch  = s.xen ? CHW'(q[0].ch) : '0;
    s.rdy = ch_rdy; s.en = out_en; s.dat = out_data; s.ch = out_ch; s.lvl = fifo_level;
    @(posedge clk);
    if (rst) begin
      q.delete(); rr = 0;
    end else begin
      if (q.size() != 0 && out_rdy) void'(q.pop_front());
      if (s.g >= 0) begin
        q.push_back('{s.g, ch_data[s.g*DW +: DW]});
        rr = (s.g + 1) % NCH;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    snap_t s;
    @(posedge clk); #1;
    for (int c = 0; c < 2; c++) begin
      cycle(s);
      n_chk++;
      if ({s.rdy, s.en, s.lvl, s.dat, s.ch} !== '0)
        $display("FAIL reset_state: rdy=%b en=%b lvl=%0d data=%h ch=%0d expected all zero",
                 s.rdy, s.en, s.lvl, s.dat, s.ch);
      else n_pass++;
    end
    rst = 1'b0;
    cycle(s);
    n_chk++;
    if (s.rdy !== 4'b0001) $display("FAIL reset_first_grant: got %b expected 0001", s.rdy);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    snap_t s;
    out_rdy = 1'b1; ch_en = '1;
    for (int i = 0; i < NCH; i++) ch_data[i*DW +: DW] = 32'hA0 + i;
    for (int c = 0; c < 16; c++) begin
      cycle(s);
      n_chk++;
      if ({s.rdy, s.en, s.lvl} !== {s.xrdy, s.xen, s.xlvl})
        $display("FAIL rr_ctrl c%0d: rdy=%b en=%b lvl=%0d expected rdy=%b en=%b lvl=%0d",
                 c, s.rdy, s.en, s.lvl, s.xrdy, s.xen, s.xlvl);
      else n_pass++;
      if (s.xen) begin
        n_chk++;
        if ({s.ch, s.dat} !== {s.xch, s.xdat})
          $display("FAIL rr_data c%0d: ch=%0d data=%h expected ch=%0d data=%h",
                   c, s.ch, s.dat, s.xch, s.xdat);
        else n_pass++;
      end
    end
  endtask

  task automatic drain();
    snap_t s;
    ch_en = '0; out_rdy = 1'b1;
    for (int c = 0; c < 20 && q.size() != 0; c++) cycle(s);
  endtask

  task automatic test_backpressure();
    snap_t s;
    int sent = 0;
    drain();
    out_rdy = 1'b0; ch_en = 4'b0100; ch_data[2*DW +: DW] = 32'hB000;
    for (int c = 0; c < 6; c++) begin
      cycle(s);
      if (s.g == 2) begin sent++; ch_data[2*DW +: DW] = 32'hB000 + sent; end
    end
    n_chk++;
    if (s.lvl !== 3'd4 || s.rdy[2] !== 1'b0)
      $display("FAIL bp_full: lvl=%0d rdy2=%b expected lvl=4 rdy2=0", s.lvl, s.rdy[2]);
    else n_pass++;
    out_rdy = 1'b1;
    cycle(s);
    if (s.g == 2) begin sent++; ch_data[2*DW +: DW] = 32'hB000 + sent; end
    n_chk++;
    if (s.rdy !== 4'b0100 || s.dat !== 32'hB000)
      $display("FAIL bp_resume: rdy=%b data=%h expected rdy=0100 data=b000", s.rdy, s.dat);
    else n_pass++;
    for (int c = 0; c < 30 && (sent < 6 || q.size() != 0); c++) begin
      if (sent >= 6) ch_en = '0;
      cycle(s);
      if (s.g == 2) begin sent++; ch_data[2*DW +: DW] = 32'hB000 + sent; end
      if (s.xen) begin
        n_chk++;
        if ({s.ch, s.dat, s.lvl} !== {s.xch, s.xdat, s.xlvl})
          $display("FAIL bp_order: ch=%0d data=%h lvl=%0d expected ch=%0d data=%h lvl=%0d",
                   s.ch, s.dat, s.lvl, s.xch, s.xdat, s.xlvl);
        else n_pass++;
      end
    end
    n_chk++;
    if (sent != 6 || q.size() != 0) $display("FAIL bp_timeout: sent=%0d left=%0d expected 6/0", sent, q.size());
    else n_pass++;
  endtask

  task automatic test_full_simul();
    snap_t s;
    drain();
    out_rdy = 1'b0; ch_en = 4'b0010; ch_data[DW +: DW] = 32'hC1;
    for (int c = 0; c < 10 && q.size() < DEP; c++) cycle(s);
    out_rdy = 1'b1;
    cycle(s);
    n_chk++;
    if (s.rdy !== 4'b0010 || s.lvl !== 3'd4)
      $display("FAIL full_simul: rdy=%b lvl=%0d expected rdy=0010 lvl=4", s.rdy, s.lvl);
    else n_pass++;
    cycle(s);
    n_chk++;
    if (s.lvl !== 3'd4 || s.en !== 1'b1) $display("FAIL full_level: lvl=%0d en=%b expected 4/1", s.lvl, s.en);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    snap_t s;
    drain();
    out_rdy = 1'b0; ch_en = 4'b0001; ch_data[0 +: DW] = 32'hDEAD;
    for (int c = 0; c < 10 && q.size() < 3; c++) cycle(s);
    ch_en = '0;
    cycle(s);
    n_chk++;
    if (s.lvl !== 3'd3) $display("FAIL mid_level: got %0d expected 3", s.lvl);
    else n_pass++;
    rst = 1'b1;
    cycle(s);
    rst = 1'b0; ch_en = 4'b0011; ch_data[DW +: DW] = 32'hE1;
    cycle(s);
    n_chk++;
    if (s.en !== 1'b0 || s.lvl !== 3'd0 || s.rdy !== 4'b0001)
      $display("FAIL mid_reset: en=%b lvl=%0d rdy=%b expected en=0 lvl=0 rdy=0001", s.en, s.lvl, s.rdy);
    else n_pass++;
    ch_en = 4'b0010;
    cycle(s);
    n_chk++;
    if (s.dat !== 32'hDEAD || s.ch !== 2'd0 || s.rdy !== 4'b0010)
      $display("FAIL mid_newdata: data=%h ch=%0d rdy=%b expected dead/0/0010", s.dat, s.ch, s.rdy);
    else n_pass++;
  endtask

  task automatic test_random();
    snap_t s;
    drain();
    for (int c = 0; c < 400; c++) begin
      out_rdy = 1'($urandom_range(0, 3) != 0);
      for (int i = 0; i < NCH; i++)
        if (!ch_en[i] && $urandom_range(0, 1) == 1) begin
          ch_en[i] = 1'b1; ch_data[i*DW +: DW] = $urandom;
        end
      cycle(s);
      if (s.g >= 0) ch_en[s.g] = 1'b0;
      n_chk++;
      if ({s.rdy, s.en, s.lvl} !== {s.xrdy, s.xen, s.xlvl})
        $display("FAIL rand_ctrl c%0d: rdy=%b en=%b lvl=%0d expected rdy=%b en=%b lvl=%0d",
                 c, s.rdy, s.en, s.lvl, s.xrdy, s.xen, s.xlvl);
      else n_pass++;
      if (s.xen) begin
        n_chk++;
        if ({s.ch, s.dat} !== {s.xch, s.xdat})
          $display("FAIL rand_data c%0d: ch=%0d data=%h expected ch=%0d data=%h",
                   c, s.ch, s.dat, s.xch, s.xdat);
        else n_pass++;
      end
    end
  endtask

`ifdef MY_MST_CHAN_MUX_STATS_EN
  task automatic test_stats();
    snap_t s;
    rst = 1'b1; ch_en = '0;
    cycle(s);
    rst = 1'b0; ch_en = 4'b1000; out_rdy = 1'b1;
    repeat (70000) begin @(posedge clk); end
    #1; ch_en = '0;
    n_chk++;
    if (stats_cnt !== {16'hFFFF, 48'h0})
      $display("FAIL stats_sat: got %h expected ffff000000000000", stats_cnt);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_full_simul();
    test_mid_reset();
    test_random();
`ifdef MY_MST_CHAN_MUX_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
